// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, DEPTH limits and counter sizing helpers for pipe_stage_reg
package pipe_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 2;
    localparam int INC_W     = 2;

    function automatic bit depth_ok(input int depth);
        return depth >= DEPTH_MIN && depth <= DEPTH_MAX;
    endfunction

    function automatic int sat_sum_w(input int cnt_w);
        return cnt_w + 1;
    endfunction
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating counter, +0..2 per cycle; ports clk_i, rst_i (sync active-low), inc_i, cnt_o
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    localparam int SUM_W = sat_sum_w(CNT_W);

    logic [SUM_W-1:0] sum;

    assign sum = {1'b0, cnt_o} + SUM_W'(inc_i);

    always_ff @(posedge clk_i) begin
        if (!rst_i) cnt_o <= '0;
        else        cnt_o <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with flush and optional skid entry
//   clk_i, rst_i (sync active-low), flush_i, in_valid_i/in_ready_o/in_data_i,
//   out_valid_o/out_ready_i/out_data_o; with PIPE_STAGE_PERF_EN also stall_cnt_o, kill_cnt_o
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = 64,
    parameter int                 DEPTH     = 2,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  kill_cnt_o
`endif
);
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH must be 1 or 2");
    end

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic              in_fire, out_fire;

    assign out_valid_o = state_q != ST_EMPTY;
    assign out_data_o  = out_valid_o ? main_q : NOP_VALUE;
    // DEPTH=2 decodes ready from state alone so out_ready_i never reaches in_ready_o
    assign in_ready_o  = (DEPTH == 2) ? (state_q != ST_FULL) : (!out_valid_o || out_ready_i);
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data_i;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end else if (in_fire) begin
                        skid_d  = in_data_i;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        main_d  = NOP_VALUE;
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [INC_W-1:0] live_n, kill_inc, stall_inc;

    // an entry leaving via out_fire during a flush was delivered, not killed
    assign live_n    = (state_q == ST_FULL) ? 2'd2 : (state_q == ST_ONE) ? 2'd1 : 2'd0;
    assign kill_inc  = flush_i ? live_n - {1'b0, out_fire} : 2'd0;
    assign stall_inc = {1'b0, out_valid_o && !out_ready_i};

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_kill_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (kill_inc),
        .cnt_o (kill_cnt_o)
    );
`else
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stage_reg: CNT_W must be positive");
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of pipe_stage_reg for DEPTH=2 (a_*) and DEPTH=1 (b_*)
module tb_pipe_stage_reg;
    localparam int          DW  = 16;
    localparam logic [15:0] NOP = 16'h0BAD;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          a_iv = 1'b0, a_ir, a_ov, a_ordy = 1'b0;
    logic [DW-1:0] a_id = '0, a_od;
    logic          b_iv = 1'b0, b_ir, b_ov, b_ordy = 1'b0;
    logic [DW-1:0] b_id = '0, b_od;
`ifdef PIPE_STAGE_PERF_EN
    logic [3:0]    a_sc, a_kc, b_sc, b_kc;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    pipe_stage_reg #(.DATA_W(DW), .DEPTH(2), .NOP_VALUE(NOP), .CNT_W(4)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_id),
        .out_valid_o(a_ov), .out_ready_i(a_ordy), .out_data_o(a_od)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(a_sc), .kill_cnt_o(a_kc)
`endif
    );

    pipe_stage_reg #(.DATA_W(DW), .DEPTH(1), .NOP_VALUE(NOP), .CNT_W(4)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_id),
        .out_valid_o(b_ov), .out_ready_i(b_ordy), .out_data_o(b_od)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(b_sc), .kill_cnt_o(b_kc)
`endif
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; flush_i = 1'b0; a_iv = 1'b0; b_iv = 1'b0; a_ordy = 1'b0; b_ordy = 1'b0;
        tick(); tick();
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL reset_a_valid: got %b want 0", a_ov); end
        total++; if (a_od !== NOP) begin bad++; $display("FAIL reset_a_data: got %h want %h", a_od, NOP); end
        total++; if (a_ir !== 1'b1) begin bad++; $display("FAIL reset_a_ready: got %b want 1", a_ir); end
        total++; if (b_ov !== 1'b0) begin bad++; $display("FAIL reset_b_valid: got %b want 0", b_ov); end
        total++; if (b_ir !== 1'b1) begin bad++; $display("FAIL reset_b_ready: got %b want 1", b_ir); end
`ifdef PIPE_STAGE_PERF_EN
        total++; if (a_sc !== 4'd0 || a_kc !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", a_sc, a_kc); end
`endif
        rst_i = 1'b1;
    endtask

    task automatic test_stream();
        a_ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_iv = 1'b1; a_id = DW'(i + 1);
            tick();
            total++; if (a_ov !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, a_ov); end
            total++; if (a_od !== DW'(i + 1)) begin bad++; $display("FAIL stream_data[%0d]: got %h want %h", i, a_od, DW'(i + 1)); end
            total++; if (a_ir !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d]: got %b want 1", i, a_ir); end
        end
        a_iv = 1'b0;
        tick();
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL stream_drain_valid: got %b want 0", a_ov); end
        total++; if (a_od !== NOP) begin bad++; $display("FAIL stream_drain_data: got %h want %h", a_od, NOP); end
    endtask

    task automatic test_backpressure();
        a_ordy = 1'b0; a_iv = 1'b1; a_id = 16'hA;
        tick();
        total++; if (a_ir !== 1'b1 || a_od !== 16'hA) begin bad++; $display("FAIL bp_first: got ready=%b data=%h want 1/000a", a_ir, a_od); end
        a_id = 16'hB;
        tick();
        total++; if (a_ir !== 1'b0) begin bad++; $display("FAIL bp_full_ready: got %b want 0", a_ir); end
        a_id = 16'hC;
        tick();
        total++; if (a_ir !== 1'b0 || a_od !== 16'hA || a_ov !== 1'b1) begin bad++; $display("FAIL bp_hold: got ready=%b valid=%b data=%h want 0/1/000a", a_ir, a_ov, a_od); end
        a_ordy = 1'b1;
        tick();
        total++; if (a_od !== 16'hB || a_ir !== 1'b1) begin bad++; $display("FAIL bp_release_b: got data=%h ready=%b want 000b/1", a_od, a_ir); end
        tick();
        total++; if (a_od !== 16'hC || a_ov !== 1'b1) begin bad++; $display("FAIL bp_release_c: got data=%h valid=%b want 000c/1", a_od, a_ov); end
        a_iv = 1'b0;
        tick();
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", a_ov); end
    endtask

    task automatic test_flush();
        a_ordy = 1'b0; a_iv = 1'b1; a_id = 16'hA;
        tick();
        a_id = 16'hB;
        tick();
        flush_i = 1'b1; a_id = 16'hD;
        tick();
        total++; if (a_ov !== 1'b0 || a_od !== NOP || a_ir !== 1'b1) begin bad++; $display("FAIL flush_full: got valid=%b data=%h ready=%b want 0/%h/1", a_ov, a_od, a_ir, NOP); end
`ifdef PIPE_STAGE_PERF_EN
        total++; if (a_kc !== 4'd2) begin bad++; $display("FAIL flush_kill2: got %0d want 2", a_kc); end
`endif
        a_id = 16'hE;
        tick();
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL flush_discard_in: got valid=%b want 0", a_ov); end
        flush_i = 1'b0; a_iv = 1'b0; a_ordy = 1'b1;
        tick();
        total++; if (a_ov !== 1'b0 || a_od !== NOP) begin bad++; $display("FAIL flush_no_ghost: got valid=%b data=%h want 0/%h", a_ov, a_od, NOP); end
        a_iv = 1'b1; a_id = 16'h5;
        tick();
        flush_i = 1'b1; a_iv = 1'b0;
        tick();
`ifdef PIPE_STAGE_PERF_EN
        total++; if (a_kc !== 4'd2) begin bad++; $display("FAIL flush_consumed: got %0d want 2", a_kc); end
`endif
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL flush_one_valid: got %b want 0", a_ov); end
        flush_i = 1'b0; a_ordy = 1'b0; a_iv = 1'b1; a_id = 16'h6;
        tick();
        flush_i = 1'b1; a_iv = 1'b0;
        tick();
        flush_i = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
        total++; if (a_kc !== 4'd3) begin bad++; $display("FAIL flush_kill1: got %0d want 3", a_kc); end
`endif
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL flush_stalled_one: got %b want 0", a_ov); end
    endtask

    task automatic test_reset_mid_stall();
        a_ordy = 1'b0; a_iv = 1'b1; a_id = 16'h7;
        tick();
        a_id = 16'h8;
        tick();
        rst_i = 1'b0; flush_i = 1'b1;
        tick();
        total++; if (a_ov !== 1'b0 || a_od !== NOP || a_ir !== 1'b1) begin bad++; $display("FAIL rst_mid: got valid=%b data=%h ready=%b want 0/%h/1", a_ov, a_od, a_ir, NOP); end
`ifdef PIPE_STAGE_PERF_EN
        total++; if (a_sc !== 4'd0 || a_kc !== 4'd0) begin bad++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", a_sc, a_kc); end
`endif
        rst_i = 1'b1; flush_i = 1'b0; a_iv = 1'b0;
    endtask

    task automatic test_depth1();
        b_ordy = 1'b1; b_iv = 1'b1; b_id = 16'h11;
        tick();
        total++; if (b_ov !== 1'b1 || b_od !== 16'h11 || b_ir !== 1'b1) begin bad++; $display("FAIL d1_first: got valid=%b data=%h ready=%b want 1/0011/1", b_ov, b_od, b_ir); end
        b_ordy = 1'b0; b_id = 16'h12;
        #1;
        total++; if (b_ir !== 1'b0) begin bad++; $display("FAIL d1_ready_low: got %b want 0", b_ir); end
        tick();
        total++; if (b_od !== 16'h11 || b_ov !== 1'b1) begin bad++; $display("FAIL d1_stall_hold: got data=%h valid=%b want 0011/1", b_od, b_ov); end
        b_ordy = 1'b1;
        #1;
        total++; if (b_ir !== 1'b1) begin bad++; $display("FAIL d1_ready_high: got %b want 1", b_ir); end
        tick();
        total++; if (b_od !== 16'h12) begin bad++; $display("FAIL d1_next: got %h want 0012", b_od); end
        b_iv = 1'b0;
        tick();
        total++; if (b_ov !== 1'b0 || b_od !== NOP) begin bad++; $display("FAIL d1_empty: got valid=%b data=%h want 0/%h", b_ov, b_od, NOP); end
    endtask

    task automatic test_saturation();
`ifdef PIPE_STAGE_PERF_EN
        a_ordy = 1'b0; a_iv = 1'b1; a_id = 16'h9;
        tick();
        a_iv = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                total++; if (a_sc !== 4'd14) begin bad++; $display("FAIL stall_cnt14: got %0d want 14", a_sc); end
            end
        end
        total++; if (a_sc !== 4'd15) begin bad++; $display("FAIL stall_sat: got %0d want 15", a_sc); end
        total++; if (a_od !== 16'h9) begin bad++; $display("FAIL stall_data: got %h want 0009", a_od); end
`endif
        a_ordy = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_depth1();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
